// File: rtl/bcd_display_ctrl_if.sv
// Handshake and result bus between a binary-value producer and the BCD display controller.
// The producer drives start/bin_in/dp_en; the controller returns busy/done/ovf and the packed value.
interface bcd_display_ctrl_if #(
    parameter int BIN_W = 20
);
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             dp_en;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [25:0]      value;

    modport master (
        output start, bin_in, dp_en,
        input  busy, done, ovf, value
    );

    modport slave (
        input  start, bin_in, dp_en,
        output busy, done, ovf, value
    );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Sequential double-dabble binary-to-BCD converter feeding the 6-digit display value bus.
// One input bit is consumed per clock; value only changes when a conversion completes.
module bcd_display_ctrl #(
    parameter int BIN_W   = 20,
    parameter int DIGITS  = 6,
    parameter int MAX_VAL = 999999
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_display_ctrl_if.slave   bus
);
    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [BCD_W-1:0] SAT_BCD  = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] scratch;
    logic [BCD_W-1:0] scratch_adj;
    logic             dp_r;
    logic             ovf_next;

    // Per-digit add-3 correction; each nibble is handled independently, no carry between digits.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        logic [3:0]       d;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            d = bcd[i*4 +: 4];
            if (d >= 4'd5) begin
                res[i*4 +: 4] = d + 4'd3;
            end
        end
        return res;
    endfunction

    always_comb begin
        scratch_adj = dabble_adj(scratch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bin_sr    <= '0;
            scratch   <= '0;
            dp_r      <= 1'b0;
            ovf_next  <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.ovf   <= 1'b0;
            bus.value <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_sr   <= bus.bin_in;
                        dp_r     <= bus.dp_en;
                        ovf_next <= (bus.bin_in > MAX_BIN);
                        scratch  <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // MSB of the operand enters the corrected BCD scratch from the right.
                    scratch <= {scratch_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
                    bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.value <= {dp_r, 1'b0, (ovf_next ? SAT_BCD : scratch)};
                    bus.ovf   <= ovf_next;
                    bus.done  <= 1'b1;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
